// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache for the MEM stage
//
// Purpose: services MEM-stage loads and stores from a direct-mapped array,
// stalls the pipeline on a miss, and moves whole lines to and from main
// memory over a request/ready handshake (write-back of a dirty victim, then
// refill).
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_mem_read, in_mem_write       load / store request (never both high)
//   in_addr, in_wdata, in_funct3    byte address, store data, access size/sign
//   out_rdata                       load result (0 when no load hit)
//   out_stall                       pipeline stall while a miss is serviced
//   out_mem_req, out_mem_we         memory request valid, 1=write-back 0=refill
//   out_mem_addr, out_mem_wdata     line-aligned address, victim line
//   in_mem_ready, in_mem_rdata      one-cycle completion pulse, refill line
module data_cache #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 16,
  localparam int LINE_BITS = 8 * LINE_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic [31:0]          in_addr,
  input  logic [31:0]          in_wdata,
  input  logic [2:0]           in_funct3,
  output logic [31:0]          out_rdata,
  output logic                 out_stall,
  output logic                 out_mem_req,
  output logic                 out_mem_we,
  output logic [31:0]          out_mem_addr,
  output logic [LINE_BITS-1:0] out_mem_wdata,
  input  logic                 in_mem_ready,
  input  logic [LINE_BITS-1:0] in_mem_rdata
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0]   data_q [NUM_LINES];

  logic [OFF_W-1:0]       off, aoff;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [OFF_W+2:0]       bit_sh;
  logic                   access, hit;
  logic [31:0]            word;
  logic [LINE_BITS-1:0]   line, mask_base, st_mask, st_data, merged;

  assign off    = in_addr[OFF_W-1:0];
  assign idx    = in_addr[OFF_W +: IDX_W];
  assign tag    = in_addr[31 -: TAG_W];
  assign access = in_mem_read | in_mem_write;
  assign line   = data_q[idx];
  assign hit    = valid_q[idx] && (tag_q[idx] == tag);

  // Halfword and word accesses ignore the low address bits instead of trapping.
  always_comb begin
    aoff      = off;
    mask_base = LINE_BITS'(8'hFF);
    case (in_funct3[1:0])
      2'd1: begin
        aoff      = {off[OFF_W-1:1], 1'b0};
        mask_base = LINE_BITS'(16'hFFFF);
      end
      2'd2: begin
        aoff      = {off[OFF_W-1:2], 2'b00};
        mask_base = LINE_BITS'(32'hFFFF_FFFF);
      end
      default: ;
    endcase
  end

  assign bit_sh  = {aoff, 3'b000};
  assign word    = 32'(line >> bit_sh);
  assign st_mask = mask_base << bit_sh;
  assign st_data = LINE_BITS'(in_wdata) << bit_sh;
  assign merged  = (line & ~st_mask) | (st_data & st_mask);

  always_comb begin
    out_rdata = 32'd0;
    if (state_q == IDLE && in_mem_read && hit) begin
      case (in_funct3)
        3'd0:    out_rdata = {{24{word[7]}}, word[7:0]};
        3'd1:    out_rdata = {{16{word[15]}}, word[15:0]};
        3'd2:    out_rdata = word;
        3'd4:    out_rdata = {24'd0, word[7:0]};
        3'd5:    out_rdata = {16'd0, word[15:0]};
        default: out_rdata = 32'd0;
      endcase
    end
  end

  assign out_stall = (state_q != IDLE) | (access & ~hit);

  // Request outputs are decoded from the state and the held request, so they
  // stay stable for as long as memory withholds ready.
  always_comb begin
    state_d       = state_q;
    out_mem_req   = 1'b0;
    out_mem_we    = 1'b0;
    out_mem_addr  = 32'd0;
    out_mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (access && !hit) state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
      end
      WB: begin
        out_mem_req   = 1'b1;
        out_mem_we    = 1'b1;
        out_mem_addr  = {tag_q[idx], idx, {OFF_W{1'b0}}};
        out_mem_wdata = line;
        if (in_mem_ready) state_d = FILL;
      end
      FILL: begin
        out_mem_req  = 1'b1;
        out_mem_addr = {tag, idx, {OFF_W{1'b0}}};
        if (in_mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FILL && in_mem_ready) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (state_q == IDLE && in_mem_write && hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == FILL && in_mem_ready) begin
        data_q[idx] <= in_mem_rdata;
        tag_q[idx]  <= tag;
      end else if (state_q == IDLE && in_mem_write && hit) begin
        data_q[idx] <= merged;
      end
    end
  end

endmodule
